muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit that owns the HI/LO register pair for the EX stage.
- Takes MULT/MULTU/DIV/DIVU operands from the ID/EX stage. Produces HI/LO, which the ALU's MFHI/MFLO path reads as operands.
- Drives a busy flag to the hazard unit, which stalls MFHI/MFLO and any new mult/div until completion.
- Replaces single-cycle combinational multiply/divide with a radix-2 shift-add / restoring-divide datapath.

Parameters:
- WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH.

Ports:
- iCLK  input  1  clock, rising edge.
- iRST_n  input  1  asynchronous active-low reset.
- iStart  input  1  start request, sampled only in IDLE.
- iOp  input  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU.
- iA  input  WIDTH  rs operand (multiplicand / dividend).
- iB  input  WIDTH  rt operand (multiplier / divisor).
- iMTHI  input  1  write iWData to HI.
- iMTLO  input  1  write iWData to LO.
- iWData  input  WIDTH  MTHI/MTLO data.
- oBusy  output  1  operation in flight (registered).
- oDone  output  1  one-cycle pulse: HI/LO just updated by mult/div.
- oDivByZero  output  1  pulses with oDone when the divisor was 0.
- oHI  output  WIDTH  HI register.
- oLO  output  WIDTH  LO register.

Behaviour:
- Reset (async, iRST_n=0): state=IDLE; HI=LO=0; oBusy=oDone=oDivByZero=0; counter and datapath registers cleared. Reset mid-operation aborts the operation with no oDone.
- FSM states:
  - IDLE: iStart=1 at edge E0 → capture operands; signed ops capture magnitudes plus sign bits. Go to CALC with count=0 and oBusy<=1.
  - CALC: one iteration per edge, E1..E32. Count 0..WIDTH-1; after the iteration at count=WIDTH-1 → FIX.
  - FIX (edge E33): apply sign correction, write HI/LO, oDone<=1, oBusy<=0 → IDLE.
- Latency: results visible on oHI/oLO, with oDone=1, in the cycle after E33, i.e. 33 cycles after the start edge. oDone lasts exactly one cycle.
- Multiply: 64-bit product {HI,LO}.
  - MULT: product negated (two's complement, 64-bit) when the operand signs differ.
  - MULTU: no sign handling.
- Divide: LO=quotient, HI=remainder.
  - DIV: quotient negated when signs differ; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (wraps, no trap).
- Divide by zero: detected at E0. Full latency is still taken. Result is LO=0xFFFFFFFF and HI=raw iA for both DIV and DIVU, with no sign correction. oDivByZero pulses with oDone.
- iStart while oBusy=1: ignored, no queueing.
- iMTHI/iMTLO in IDLE: write HI/LO at the edge. Both may be asserted together; each writes its own register.
- iMTHI/iMTLO while busy: abort the operation (→ IDLE, oBusy<=0, no oDone), then perform the write.
- Simultaneous iStart and iMTHI/iMTLO in IDLE: the MT write wins and the start is dropped.
- oHI/oLO hold their previous values throughout CALC and change only at FIX, MT writes, or reset.
- Invalid/X iOp is not possible; all four encodings are defined.

Optional Feature:
- Macro: MULDIV_FAST_MULT_EN.
- Defined: MULT/MULTU bypass CALC. E0 captures operands → FIX. E1 writes the product from a combinational WIDTHxWIDTH multiplier, so oDone appears 1 cycle after start. Division is unchanged (33 cycles).
- Undefined: all ops iterate with 33-cycle latency, and no wide multiplier is inferred.

Test Plan:
- MULT iA=0xFFFFFFFE, iB=3 → at E33: HI=0xFFFFFFFF, LO=0xFFFFFFFA, oDone one cycle, oBusy high E1..E33 only.
- MULTU iA=0xFFFFFFFE, iB=3 → HI=0x00000002, LO=0xFFFFFFFA. With MULDIV_FAST_MULT_EN, the same result with oDone 1 cycle after start.
- DIV iA=0xFFFFFFF9 (-7), iB=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU with the same operands → LO=0x7FFFFFFC, HI=0x00000001.
- DIVU iA=0x64, iB=0 → LO=0xFFFFFFFF, HI=0x00000064, oDivByZero=1 coincident with oDone.
- Start MULT; at cycle 10 pulse iStart with new operands (ignored), then drop iRST_n low → HI=LO=0, oBusy=0 immediately, no oDone after release.
- Start DIV; at cycle 5 assert iMTLO with iWData=0x12345678 → oBusy=0 next cycle, LO=0x12345678, HI unchanged, no oDone ever fires.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Define MULDIV_FAST_MULT_EN to compute MULT/MULTU with a single-cycle multiplier.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             iCLK,
    input  logic             iRST_n,
    input  logic             iStart,
    input  logic [1:0]       iOp,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic             iMTHI,
    input  logic             iMTLO,
    input  logic [WIDTH-1:0] iWData,
    output logic             oBusy,
    output logic             oDone,
    output logic             oDivByZero,
    output logic [WIDTH-1:0] oHI,
    output logic [WIDTH-1:0] oLO,
    output logic [1:0]       oDbgState
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] p_hi_q, p_hi_d;
    logic [WIDTH-1:0] p_lo_q, p_lo_d;
    logic             is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             div0_q, div0_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic             div_ge;
    logic [2*WIDTH-1:0] prod, prod_neg;

    assign a_neg = ~iOp[0] & iA[WIDTH-1];
    assign b_neg = ~iOp[0] & iB[WIDTH-1];
    assign a_mag = a_neg ? ('0 - iA) : iA;
    assign b_mag = b_neg ? ('0 - iB) : iB;

    // m_q holds the multiplicand (mult) or the divisor (div).
    assign mul_sum   = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, m_q} : '0);
    assign div_shift = {p_hi_q, p_lo_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, m_q};
    assign div_ge    = ~div_diff[WIDTH];
    assign prod      = {p_hi_q, p_lo_q};
    assign prod_neg  = '0 - prod;

`ifdef MULDIV_FAST_MULT_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        m_d       = m_q;
        p_hi_d    = p_hi_q;
        p_lo_d    = p_lo_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dbz_d     = 1'b0;

        if (iMTHI || iMTLO) begin
            // MT writes abort any operation in flight and block a same-cycle start.
            state_d = S_IDLE;
            busy_d  = 1'b0;
            cnt_d   = '0;
            if (iMTHI) hi_d = iWData;
            if (iMTLO) lo_d = iWData;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (iStart) begin
                        is_div_d  = iOp[1];
                        neg_res_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        div0_d    = iOp[1] && (iB == '0);
                        cnt_d     = '0;
                        busy_d    = 1'b1;
                        state_d   = S_CALC;
                        p_hi_d    = '0;
                        if (iOp[1]) begin
                            p_lo_d = a_mag;
                            // On divide-by-zero the iterations are don't-care; keep raw A for HI.
                            m_d    = (iB == '0) ? iA : b_mag;
                        end else begin
                            p_lo_d = b_mag;
                            m_d    = a_mag;
`ifdef MULDIV_FAST_MULT_EN
                            {p_hi_d, p_lo_d} = fast_prod;
                            state_d          = S_FIX;
`endif
                        end
                    end
                end
                S_CALC: begin
                    if (is_div_q) begin
                        p_hi_d = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                        p_lo_d = {p_lo_q[WIDTH-2:0], div_ge};
                    end else begin
                        p_hi_d = mul_sum[WIDTH:1];
                        p_lo_d = {mul_sum[0], p_lo_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
                end
                S_FIX: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    dbz_d   = div0_q;
                    if (div0_q) begin
                        hi_d = m_q;
                        lo_d = '1;
                    end else if (is_div_q) begin
                        lo_d = neg_res_q ? ('0 - p_lo_q) : p_lo_q;
                        hi_d = neg_rem_q ? ('0 - p_hi_q) : p_hi_q;
                    end else begin
                        {hi_d, lo_d} = neg_res_q ? prod_neg : prod;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            m_q       <= '0;
            p_hi_q    <= '0;
            p_lo_q    <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            m_q       <= m_d;
            p_hi_q    <= p_hi_d;
            p_lo_q    <= p_lo_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign oBusy      = busy_q;
    assign oDone      = done_q;
    assign oDivByZero = dbz_q;
    assign oHI        = hi_q;
    assign oLO        = lo_q;
    assign oDbgState  = state_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed + random bench for muldiv_unit; results flow through an expected-value queue.
module tb_muldiv_unit;
    localparam int W = 32;
`ifdef MULDIV_FAST_MULT_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic         iCLK = 1'b0;
    logic         iRST_n = 1'b0;
    logic         iStart = 1'b0;
    logic [1:0]   iOp = 2'd0;
    logic [W-1:0] iA = '0;
    logic [W-1:0] iB = '0;
    logic         iMTHI = 1'b0;
    logic         iMTLO = 1'b0;
    logic [W-1:0] iWData = '0;
    logic         oBusy, oDone, oDivByZero;
    logic [W-1:0] oHI, oLO;
    logic [1:0]   oDbgState;

    muldiv_unit #(.WIDTH(W)) dut (
        .iCLK(iCLK), .iRST_n(iRST_n), .iStart(iStart), .iOp(iOp), .iA(iA), .iB(iB),
        .iMTHI(iMTHI), .iMTLO(iMTLO), .iWData(iWData),
        .oBusy(oBusy), .oDone(oDone), .oDivByZero(oDivByZero),
        .oHI(oHI), .oLO(oLO), .oDbgState(oDbgState)
    );

    always #5 iCLK = ~iCLK;

    int vectors = 0;
    int errors  = 0;
    logic [W-1:0] exp_hi_q[$];
    logic [W-1:0] exp_lo_q[$];
    logic         exp_dbz_q[$];
    logic [W-1:0] last_hi = '0;
    logic [W-1:0] last_lo = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: {dbz, hi, lo} from plain 64-bit arithmetic.
    function automatic logic [2*W:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] sa, sb, q, r;
        logic [2*W-1:0] p;
        sa = op[0] ? {{W{1'b0}}, a} : {{W{a[W-1]}}, a};
        sb = op[0] ? {{W{1'b0}}, b} : {{W{b[W-1]}}, b};
        if (!op[1]) begin
            p = sa * sb;
            return {1'b0, p};
        end
        if (b == '0) return {1'b1, a, {W{1'b1}}};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[W-1:0], q[W-1:0]};
    endfunction

    // Start an op, optionally poke iStart while busy, and score the result.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edbz,
                          input int exp_lat, input int poke_at, input string tag);
        int lat;
        logic busy_all;
        @(negedge iCLK);
        iStart = 1'b1; iOp = op; iA = a; iB = b;
        exp_hi_q.push_back(ehi);
        exp_lo_q.push_back(elo);
        exp_dbz_q.push_back(edbz);
        @(negedge iCLK);
        iStart = 1'b0; iA = $urandom; iB = $urandom;
        lat = 0;
        busy_all = 1'b1;
        while (oDone !== 1'b1 && lat < 200) begin
            if (oBusy !== 1'b1) busy_all = 1'b0;
            if (lat > 0 && lat < exp_lat && (oHI !== last_hi || oLO !== last_lo)) busy_all = 1'b0;
            iStart = (lat == poke_at);
            if (lat == poke_at) iOp = ~op;
            @(negedge iCLK);
            lat++;
        end
        iStart = 1'b0;
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " busy+hold during op"}, 64'(busy_all), 64'd1);
        if (oDone === 1'b1) begin
            check({tag, " HI"}, 64'(oHI), 64'(exp_hi_q.pop_front()));
            check({tag, " LO"}, 64'(oLO), 64'(exp_lo_q.pop_front()));
            check({tag, " divbyzero"}, 64'(oDivByZero), 64'(exp_dbz_q.pop_front()));
            check({tag, " busy at done"}, 64'(oBusy), 64'd0);
        end
        last_hi = oHI;
        last_lo = oLO;
        @(negedge iCLK);
        check({tag, " done one cycle"}, 64'(oDone), 64'd0);
    endtask

    task automatic watch_no_done(input int cycles, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge iCLK);
            if (oDone !== 1'b0 || oBusy !== 1'b0) seen = 1'b1;
        end
        check({tag, " no done/busy"}, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [2*W:0] m;
        logic [1:0] rop;
        logic [W-1:0] ra, rb;

        // Reset state
        #12;
        check("reset HI", 64'(oHI), 64'd0);
        check("reset LO", 64'(oLO), 64'd0);
        check("reset busy", 64'(oBusy), 64'd0);
        check("reset done", 64'(oDone | oDivByZero), 64'd0);
        @(negedge iCLK);
        iRST_n = 1'b1;

        // Directed vectors
        run_op(2'b00, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, MUL_LAT, -1, "MULT -2*3");
        run_op(2'b01, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, 1'b0, MUL_LAT, -1, "MULTU");
        run_op(2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, DIV_LAT, -1, "DIV -7/2");
        run_op(2'b11, 32'hFFFFFFF9, 32'd2, 32'h00000001, 32'h7FFFFFFC, 1'b0, DIV_LAT, -1, "DIVU");
        run_op(2'b11, 32'h00000064, 32'd0, 32'h00000064, 32'hFFFFFFFF, 1'b1, DIV_LAT, -1, "DIVU by 0");
        run_op(2'b10, 32'h80000005, 32'd0, 32'h80000005, 32'hFFFFFFFF, 1'b1, DIV_LAT, -1, "DIV by 0");
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, DIV_LAT, -1, "DIV overflow");
        run_op(2'b10, 32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2, 1'b0, DIV_LAT, 3, "DIV start ignored");
        run_op(2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, MUL_LAT, -1, "MULT minmin");

        // Random vectors scored against the 64-bit model
        for (int k = 0; k < 8; k++) begin
            rop = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (k % 3 == 0) ? 32'($urandom_range(1, 17)) : $urandom;
            if (k % 2 == 1) rb = ~rb + 32'd1;
            m = model(rop, ra, rb);
            run_op(rop, ra, rb, m[2*W-1:W], m[W-1:0], m[2*W], rop[1] ? DIV_LAT : MUL_LAT, -1, "random");
        end

        // Reset mid-multiply, with an ignored start pulse just before
        @(negedge iCLK);
        iStart = 1'b1; iOp = 2'b01; iA = 32'd12345; iB = 32'd678;
        @(negedge iCLK);
        iStart = 1'b0;
        repeat (10) @(negedge iCLK);
        check("hold HI during CALC", 64'(oHI), 64'(last_hi));
        iStart = 1'b1; iA = 32'd5; iB = 32'd7;
        @(posedge iCLK);
        #2;
        iStart = 1'b0;
        iRST_n = 1'b0;
        #1;
        check("abort reset HI", 64'(oHI), 64'd0);
        check("abort reset LO", 64'(oLO), 64'd0);
        check("abort reset busy", 64'(oBusy), 64'd0);
        @(negedge iCLK);
        iRST_n = 1'b1;
        watch_no_done(40, "after reset");

        // MTHI in idle
        iMTHI = 1'b1; iWData = 32'hCAFEF00D;
        @(negedge iCLK);
        iMTHI = 1'b0;
        check("MTHI idle HI", 64'(oHI), 64'hCAFEF00D);
        check("MTHI idle LO kept", 64'(oLO), 64'd0);

        // MTLO aborts a divide in flight
        iStart = 1'b1; iOp = 2'b10; iA = 32'd1000; iB = 32'd7;
        @(negedge iCLK);
        iStart = 1'b0;
        repeat (5) @(negedge iCLK);
        iMTLO = 1'b1; iWData = 32'h12345678;
        @(negedge iCLK);
        iMTLO = 1'b0;
        check("MTLO abort busy", 64'(oBusy), 64'd0);
        check("MTLO abort LO", 64'(oLO), 64'h12345678);
        check("MTLO abort HI kept", 64'(oHI), 64'hCAFEF00D);
        watch_no_done(40, "after MT abort");

        // MTHI+MTLO together with a start: writes win, start dropped
        iStart = 1'b1; iOp = 2'b01; iA = 32'd3; iB = 32'd3;
        iMTHI = 1'b1; iMTLO = 1'b1; iWData = 32'h0BADBEEF;
        @(negedge iCLK);
        iStart = 1'b0; iMTHI = 1'b0; iMTLO = 1'b0;
        check("MT both HI", 64'(oHI), 64'h0BADBEEF);
        check("MT both LO", 64'(oLO), 64'h0BADBEEF);
        watch_no_done(40, "start dropped");

        check("scoreboard drained", 64'(exp_hi_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
